mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port, variable-latency unified memory between the CPU instruction-fetch port and the CPU load/store data port.
- Sits between the CPU core (pc/instr, alu_result/write_data/read_data/mem_write) and the memory model.
- Serialises accesses and arbitrates round-robin on ties.
- Drives a stall so the core holds its state while its access is outstanding. A timeout aborts hung memory transactions.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 16, max cycles mem_req may wait for mem_ready before abort (>=2)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low (0 = in reset)
- i_req  in  1  fetch request (the core drives this permanently high while running)
- i_addr  in  ADDR_W  fetch address (pc)
- i_rdata  out  DATA_W  fetched instruction
- i_done  out  1  one-cycle pulse: fetch complete, i_rdata valid
- d_req  in  1  data request
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address (alu_result)
- d_wdata  in  DATA_W  store data (write_data)
- d_rdata  out  DATA_W  load data (read_data)
- d_done  out  1  one-cycle pulse: data access complete
- err  out  1  one-cycle pulse with i_done/d_done when the access timed out
- stall  out  1  (i_req & ~i_done) | (d_req & ~d_done), combinational
- mem_req  out  1  memory request, held until accepted
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_ready  in  1  memory completes the current access this cycle
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready

Behaviour:
- Reset values (asynchronous, while reset=0):
  - state=IDLE, last_grant=FETCH
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0
  - i_rdata=0, d_rdata=0
  - i_done=0, d_done=0, err=0
  - timeout counter=0
- States: IDLE, FETCH, DATA.
- IDLE arbitration, evaluated every cycle:
  - only i_req -> grant FETCH
  - only d_req -> grant DATA
  - both -> grant the port not equal to last_grant, so the first tie after reset goes to DATA
  - neither -> stay IDLE
- On grant (clock edge):
  - latch addr into mem_addr; latch we/wdata for DATA (mem_we=0 for FETCH)
  - set mem_req=1, counter=0, last_grant=granted port
  - enter FETCH or DATA
- FETCH/DATA, while mem_ready=0: mem_req and mem_addr/mem_we/mem_wdata held stable; counter increments.
- Completion, cycle with mem_req=1 and mem_ready=1. On the next edge:
  - mem_req=0, mem_we=0
  - FETCH -> i_rdata<=mem_rdata, i_done=1 for one cycle
  - DATA load -> d_rdata<=mem_rdata, d_done=1 for one cycle
  - DATA store -> d_rdata unchanged, d_done=1 for one cycle
  - return to IDLE
- Timeout: when counter reaches TIMEOUT-1 with mem_ready still 0:
  - next edge drops mem_req, pulses done for the owning port together with err=1
  - loaded rdata is forced to 0, then returns to IDLE
  - mem_ready arriving in that same cycle takes precedence (normal completion, no err)
- Latency:
  - grant edge at cycle N; mem_req high from N+1; done pulse at the edge after mem_ready
  - minimum request-to-done is 2 cycles (mem_ready=1 in first mem_req cycle)
  - one IDLE cycle always follows each completion, so back-to-back accesses cost a minimum of 3 cycles each
- Requester rules:
  - req must be held with stable addr/we/wdata until its done pulse
  - req dropped before grant is simply not granted
  - req dropped after grant does not abort the access; done still pulses
- Simultaneous events:
  - done for one port and a new req on the other in the same cycle -> handled by the next IDLE arbitration
  - i_done and d_done are never high together
- Reset mid-access: mem_req drops immediately (asynchronously), no done/err pulse, pending access lost; the core must reissue.
- stall must be 0 in the cycle of the requester's done pulse so the core advances exactly once.

Test Plan:
- Reset: hold reset=0 then release -> all outputs 0, state IDLE, mem_req=0; assert reset=0 while mem_req=1 -> mem_req falls without waiting for a clock edge.
- Single fetch: i_req=1, i_addr=0, memory returns 32'he0842005 with 0 wait cycles -> mem_req high exactly 1 cycle with mem_addr=0, i_done pulse one cycle later, i_rdata=32'he0842005.
- Store with wait: d_req=1, d_we=1, d_addr=32'hff, d_wdata=7, mem_ready after 3 cycles -> mem_we=1, mem_addr=32'hff, mem_wdata=7 stable for 3 cycles, single d_done, err=0, d_rdata unchanged.
- Tie round-robin: i_req and d_req both held high from reset -> grant order DATA, FETCH, DATA, FETCH; stall high for each port until its own done.
- Timeout: TIMEOUT=16, d_req load, mem_ready never asserted -> mem_req high exactly 16 cycles, then d_done=1 and err=1 same cycle, d_rdata=0, arbiter accepts a following i_req normally.
- Boundary: mem_ready asserted in the cycle the counter hits TIMEOUT-1 with mem_rdata=32'hffffffff -> normal completion, err=0, d_rdata=32'hffffffff.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one variable-latency memory port between
// instruction fetch and load/store, with a stall output and access timeout.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              err,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DATA
    } state_t;

    state_t           state;
    logic             last_data;
    logic [CNT_W-1:0] cnt;
    logic             grant_i;
    logic             grant_d;
    logic             finish;

    // On a tie the port that did not win last time gets the memory.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        unique case (1'b1)
            (i_req & d_req): begin
                grant_i = last_data;
                grant_d = ~last_data;
            end
            (i_req & ~d_req): grant_i = 1'b1;
            (~i_req & d_req): grant_d = 1'b1;
            default: ;
        endcase
    end

    assign finish = mem_ready | (cnt == CNT_MAX);
    assign stall  = (i_req & ~i_done) | (d_req & ~d_done);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            last_data <= 1'b0;
            cnt       <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            i_done    <= 1'b0;
            d_done    <= 1'b0;
            err       <= 1'b0;
        end else begin
            i_done <= 1'b0;
            d_done <= 1'b0;
            err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_i | grant_d) begin
                        mem_req   <= 1'b1;
                        cnt       <= '0;
                        last_data <= grant_d;
                        mem_addr  <= grant_d ? d_addr : i_addr;
                        mem_we    <= grant_d & d_we;
                        if (grant_d)
                            mem_wdata <= d_wdata;
                        state <= grant_d ? DATA : FETCH;
                    end
                end
                FETCH, DATA: begin
                    if (finish) begin
                        // A late mem_ready on the last counted cycle still wins.
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        err     <= ~mem_ready;
                        state   <= IDLE;
                        if (state == FETCH) begin
                            i_done  <= 1'b1;
                            i_rdata <= mem_ready ? mem_rdata : '0;
                        end else begin
                            d_done <= 1'b1;
                            if (!mem_we)
                                d_rdata <= mem_ready ? mem_rdata : '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised bench for mem_arbiter: two requesters, a latency-randomising
// memory model, and a scoreboard checking grants, responses and timeouts.
module tb_mem_arbiter;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_rdata;
    logic        i_done;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        err;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done), .err(err), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [31:0] data;
        logic        err;
        logic        we;
    } resp_t;

    resp_t iq[$];
    resp_t dq[$];

    logic [31:0] mem_m [logic [31:0]];

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (mem_m.exists(a))
            return mem_m[a];
        return (a * 32'h9e3779b1) ^ 32'h5a5a0f0f;
    endfunction

    function automatic int pick_lat();
        int r;
        r = $urandom_range(0, 19);
        if (r < 12) return r % 4;
        if (r < 16) return r - 8;
        if (r < 18) return TO - 1;
        return TO + 4;
    endfunction

    // Requests as seen by the arbiter at each rising edge.
    logic        s_i, s_d, s_dwe;
    logic [31:0] s_iaddr, s_daddr, s_dwdata;
    always @(posedge clk) begin
        s_i      = i_req;
        s_d      = d_req;
        s_dwe    = d_we;
        s_iaddr  = i_addr;
        s_daddr  = d_addr;
        s_dwdata = d_wdata;
    end

    bit          bus_en = 0;
    bit          prev_req = 0;
    bit          last_d = 0;
    bit          active = 0;
    bit          expect_drop = 0;
    bit          cur_d;
    logic        cur_we;
    logic [31:0] cur_addr, cur_wdata;
    int          c, lat;
    logic [31:0] exp_d = '0;

    // Memory model and grant checker.
    always @(negedge clk) if (bus_en) begin
        resp_t r;
        if (expect_drop) begin
            chk("req_drop", mem_req, 0);
            expect_drop = 0;
        end else if (!prev_req) begin
            if (s_i || s_d) begin
                chk("grant", mem_req, 1);
                if (mem_req) begin
                    cur_d     = s_d && (!s_i || !last_d);
                    last_d    = cur_d;
                    cur_addr  = cur_d ? s_daddr : s_iaddr;
                    cur_we    = cur_d & s_dwe;
                    cur_wdata = s_dwdata;
                    chk("gnt_addr", mem_addr, cur_addr);
                    chk("gnt_we", mem_we, cur_we);
                    if (cur_we) chk("gnt_wdata", mem_wdata, cur_wdata);
                    c      = 0;
                    lat    = pick_lat();
                    active = 1;
                end
            end else begin
                chk("no_grant", mem_req, 0);
            end
        end else if (active) begin
            chk("hold_req", mem_req, 1);
            chk("hold_addr", mem_addr, cur_addr);
            chk("hold_we", mem_we, cur_we);
            if (cur_we) chk("hold_wdata", mem_wdata, cur_wdata);
        end
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        if (active) begin
            c++;
            if (c == lat + 1) begin
                mem_ready = 1'b1;
                if (cur_we) begin
                    mem_m[cur_addr] = cur_wdata;
                end else begin
                    mem_rdata = (lat == TO - 1) ? 32'hffffffff : rd(cur_addr);
                end
                r = '{data: mem_rdata, err: 1'b0, we: cur_we};
            end else if (c == TO) begin
                r = '{data: 32'h0, err: 1'b1, we: cur_we};
            end
            if (mem_ready || c == TO) begin
                if (cur_d) dq.push_back(r);
                else iq.push_back(r);
                expect_drop = 1;
                active = 0;
            end
        end
        prev_req = mem_req;
    end

    // Response monitor.
    always @(negedge clk) if (bus_en) begin
        resp_t r;
        logic [31:0] e;
        #1;
        chk("stall", stall, (i_req & ~i_done) | (d_req & ~d_done));
        if (i_done && d_done) chk("both_done", 1, 0);
        if (i_done) begin
            if (iq.size() == 0) begin
                chk("i_unexpected", i_done, 0);
            end else begin
                r = iq.pop_front();
                chk("i_rdata", i_rdata, r.data);
                chk("i_err", err, r.err);
            end
        end
        if (d_done) begin
            if (dq.size() == 0) begin
                chk("d_unexpected", d_done, 0);
            end else begin
                r = dq.pop_front();
                e = r.we ? exp_d : r.data;
                exp_d = e;
                chk("d_rdata", d_rdata, e);
                chk("d_err", err, r.err);
            end
        end
        if (!i_done && !d_done) chk("err_idle", err, 0);
    end

    task automatic fetch_proc(input int n);
        for (int t = 0; t < n; t++) begin
            int gap;
            int k;
            gap = (t > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            if (gap > 0) begin
                i_req = 1'b0;
                repeat (gap) @(negedge clk);
            end
            i_req  = 1'b1;
            i_addr = ($urandom_range(0, 7) == 0) ? 32'h0 : 32'($urandom_range(0, 1023)) << 2;
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!i_done && k < 100);
            chk("i_wait", i_done, 1);
        end
        i_req = 1'b0;
    endtask

    task automatic data_proc(input int n);
        for (int t = 0; t < n; t++) begin
            int gap;
            int k;
            gap = (t > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            if (gap > 0) begin
                d_req = 1'b0;
                repeat (gap) @(negedge clk);
            end
            d_req   = 1'b1;
            d_we    = $urandom_range(0, 1) == 1;
            d_addr  = ($urandom_range(0, 15) == 0) ? 32'hff :
                      32'h10000000 + (32'($urandom_range(0, 15)) << 2);
            d_wdata = ($urandom_range(0, 7) == 0) ? 32'h7 : $urandom;
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!d_done && k < 100);
            chk("d_wait", d_done, 1);
        end
        d_req = 1'b0;
    endtask

    initial begin
        mem_m[32'h0] = 32'he0842005;
        repeat (3) @(negedge clk);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_i_rdata", i_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_done", {i_done, d_done, err}, 0);
        chk("rst_stall", stall, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_mem_req", mem_req, 0);
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h1234;
        @(negedge clk);
        chk("pre_rst_req", mem_req, 1);
        chk("pre_rst_addr", mem_addr, 32'h1234);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_req", mem_req, 0);
        chk("async_rst_done", {d_done, err}, 0);
        d_req = 1'b0;
        repeat (2) @(negedge clk);
        reset  = 1'b1;
        bus_en = 1;
        fork
            fetch_proc(60);
            data_proc(60);
        join
        repeat (6) @(negedge clk);
        chk("iq_empty", iq.size(), 0);
        chk("dq_empty", dq.size(), 0);
        chk("end_mem_req", mem_req, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
